adp_thresh_seg: RTL and testbench

//  Adaptive (3x3 local-mean) binarisation stage producing the adpseg_* video stream of top.

---
 rtl/adp_thresh_seg.sv | 195 +++++++++++++++++++
 tb/tb_adp_thresh_seg.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adp_thresh_seg.sv
`default_nettype none
// ============================================================================
//  Module   : adp_thresh_seg
//  Purpose  : Adaptive 3x3 local-mean binarisation of an 8-bit grey video
//             stream. A pixel is foreground (255) when
//             center > mean(3x3) - OFFSET. Otherwise it is background (0).
//             Timing signals pass through with a fixed 3-cycle latency.
//  Ports    : clk        - pixel clock, rising edge
//             rst_n      - synchronous active-low reset
//             pre_hsync  - input line sync
//             pre_vsync  - input frame sync, rising edge starts a frame
//             pre_de     - input data enable, one pixel per cycle
//             pre_data   - input grey pixel [7:0]
//             post_hsync - pre_hsync delayed 3 cycles
//             post_vsync - pre_vsync delayed 3 cycles
//             post_de    - pre_de delayed 3 cycles
//             post_data  - binarised pixel, 0 or 255, zero when post_de=0
//  Revision : 1.0  initial release
// ============================================================================
module adp_thresh_seg #(
    parameter int         H_DISP = 1440,
    parameter int         V_DISP = 1080,
    parameter logic [7:0] OFFSET = 8'd8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pre_hsync,
    input  logic       pre_vsync,
    input  logic       pre_de,
    input  logic [7:0] pre_data,
    output logic       post_hsync,
    output logic       post_vsync,
    output logic       post_de,
    output logic [7:0] post_data
);

    localparam int CW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int RW = (V_DISP > 1) ? $clog2(V_DISP) : 1;

    // Threshold bias pre-scaled by 9, so that "center > mean - C" becomes
    // the division-free test "9*center + 9*C > sum".
    localparam logic [12:0] c_OFF9  = 13'(OFFSET) * 13'd9;
    localparam logic [CW-1:0] c_COL_MAX = CW'(H_DISP - 1);
    localparam logic [RW-1:0] c_ROW_MAX = RW'(V_DISP - 1);

    // ------------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------------
    logic          de_prev_q;
    logic          vs_prev_q;
    logic [CW-1:0] col_q, col_d;
    logic          col_ovf_q, col_ovf_d;   // line already ran past H_DISP-1
    logic [RW-1:0] row_q, row_d;
    logic          w_de_fall;
    logic          w_vs_rise;

    assign w_de_fall = de_prev_q & ~pre_de;
    assign w_vs_rise = pre_vsync & ~vs_prev_q;

    always_comb begin
        col_d     = col_q;
        col_ovf_d = col_ovf_q;
        row_d     = row_q;

        if (w_de_fall) begin
            col_d     = '0;
            col_ovf_d = 1'b0;
        end else if (pre_de) begin
            if (col_q == c_COL_MAX) begin
                col_ovf_d = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        // The frame-start clear takes priority over an end-of-line step.
        if (w_vs_rise) begin
            row_d = '0;
        end else if (w_de_fall && (row_q != c_ROW_MAX)) begin
            row_d = row_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Line buffers: LB0 holds the previous row, LB1 the row before that.
    // The contents are never reset. Stale data is masked by the row/col
    // validity tag.
    // ------------------------------------------------------------------
    logic [7:0] lb0_mem [H_DISP];
    logic [7:0] lb1_mem [H_DISP];
    logic       w_lb_we;

    assign w_lb_we = pre_de & ~col_ovf_q;

    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            lb1_mem[col_q] <= lb0_mem[col_q];
            lb0_mem[col_q] <= pre_data;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline
    //   stage 1: registered RAM read feeds window column 0, window shifts
    //   stage 2: 9-pixel sum and scaled center
    //   stage 3: compare -> post_data
    // win_q[row][col]: row 0 = r-2 (LB1), row 1 = r-1 (LB0), row 2 = r.
    //                  col 0 = c, col 1 = c-1, col 2 = c-2.
    // ------------------------------------------------------------------
    logic [7:0]  win_q [3][3];
    logic [2:0]  hs_q;
    logic [2:0]  vs_q;
    logic [2:0]  de_q;
    logic [1:0]  val_q;                   // window is fully inside the image
    logic [11:0] sum_q, sum_d;
    logic [12:0] lhs_q, lhs_d;
    logic [7:0]  data_q;
    logic        w_val_in;

    assign w_val_in = pre_de & (col_q >= CW'(2)) & (row_q >= RW'(2));

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                sum_d = sum_d + 12'(win_q[i][j]);
            end
        end
        lhs_d = 13'({win_q[1][1], 3'b000}) + 13'(win_q[1][1]) + c_OFF9;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            de_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            col_q     <= '0;
            col_ovf_q <= 1'b0;
            row_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
            hs_q   <= '0;
            vs_q   <= '0;
            de_q   <= '0;
            val_q  <= '0;
            sum_q  <= '0;
            lhs_q  <= '0;
            data_q <= '0;
        end else begin
            de_prev_q <= pre_de;
            vs_prev_q <= pre_vsync;
            col_q     <= col_d;
            col_ovf_q <= col_ovf_d;
            row_q     <= row_d;

            // Stage 1
            if (pre_de) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][2] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][0];
                end
                win_q[0][0] <= lb1_mem[col_q];
                win_q[1][0] <= lb0_mem[col_q];
                win_q[2][0] <= pre_data;
            end
            hs_q[0]  <= pre_hsync;
            vs_q[0]  <= pre_vsync;
            de_q[0]  <= pre_de;
            val_q[0] <= w_val_in;

            // Stage 2
            sum_q    <= sum_d;
            lhs_q    <= lhs_d;
            hs_q[1]  <= hs_q[0];
            vs_q[1]  <= vs_q[0];
            de_q[1]  <= de_q[0];
            val_q[1] <= val_q[0];

            // Stage 3: ties resolve to background
            hs_q[2] <= hs_q[1];
            vs_q[2] <= vs_q[1];
            de_q[2] <= de_q[1];
            data_q  <= (de_q[1] && val_q[1] && (lhs_q > {1'b0, sum_q})) ? 8'd255 : 8'd0;
        end
    end

    assign post_hsync = hs_q[2];
    assign post_vsync = vs_q[2];
    assign post_de    = de_q[2];
    assign post_data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_adp_thresh_seg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adp_thresh_seg
//  Purpose  : Self-checking bench for adp_thresh_seg (H_DISP=16, V_DISP=8).
//             Two instances share one stimulus stream: OFFSET=5 and OFFSET=0.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adp_thresh_seg;

    localparam int H = 16;
    localparam int V = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pre_hsync, pre_vsync, pre_de;
    logic [7:0] pre_data;
    logic       ph5, pv5, pd5;
    logic [7:0] pdat5;
    logic       ph0, pv0, pd0;
    logic [7:0] pdat0;

    always #5 clk = ~clk;

    adp_thresh_seg #(.H_DISP(H), .V_DISP(V), .OFFSET(8'd5)) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .pre_hsync(pre_hsync), .pre_vsync(pre_vsync), .pre_de(pre_de), .pre_data(pre_data),
        .post_hsync(ph5), .post_vsync(pv5), .post_de(pd5), .post_data(pdat5)
    );

    adp_thresh_seg #(.H_DISP(H), .V_DISP(V), .OFFSET(8'd0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .pre_hsync(pre_hsync), .pre_vsync(pre_vsync), .pre_de(pre_de), .pre_data(pre_data),
        .post_hsync(ph0), .post_vsync(pv0), .post_de(pd0), .post_data(pdat0)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stimulus tags delayed by the required latency of 3 cycles
    typedef struct packed {
        logic       rst;
        logic       hs;
        logic       vs;
        logic       de;
        logic [3:0] r;
        logic [3:0] c;
    } tag_t;

    tag_t       tag_q [3];
    logic [3:0] cur_r, cur_c;
    logic       mon_en = 1'b0;

    always @(posedge clk) begin
        tag_q[0] <= {rst_n, pre_hsync, pre_vsync, pre_de, cur_r, cur_c};
        tag_q[1] <= tag_q[0];
        tag_q[2] <= tag_q[1];
    end

    int cap5 [V][H];
    int cap0 [V][H];
    int npd5, npd0, npre;

    always @(negedge clk) begin
        if (!tag_q[0].rst) begin
            chk("reset_out5", int'({ph5, pv5, pd5, pdat5}), 0);
            chk("reset_out0", int'({ph0, pv0, pd0, pdat0}), 0);
        end
        if (mon_en && tag_q[0].rst && tag_q[1].rst && tag_q[2].rst) begin
            chk("latency5", int'({ph5, pv5, pd5}), int'({tag_q[2].hs, tag_q[2].vs, tag_q[2].de}));
            chk("latency0", int'({ph0, pv0, pd0}), int'({tag_q[2].hs, tag_q[2].vs, tag_q[2].de}));
        end
        if (mon_en && !pd5) chk("idle_data5", int'(pdat5), 0);
        if (mon_en && !pd0) chk("idle_data0", int'(pdat0), 0);
        if (pd5) begin
            cap5[tag_q[2].r][tag_q[2].c] = int'(pdat5);
            npd5++;
        end
        if (pd0) begin
            cap0[tag_q[2].r][tag_q[2].c] = int'(pdat0);
            npd0++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pix(input int pat, input int r, input int c);
        if (pat == 1) return (r == 4 && c == 6) ? 8'd200 : 8'd0;
        return 8'd100;
    endfunction

    function automatic int exp_flat(input int r, input int c);
        return (r >= 2 && c >= 2) ? 255 : 0;
    endfunction

    task automatic clear_caps();
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                cap5[r][c] = 170;
                cap0[r][c] = 170;
            end
        end
        npd5 = 0;
        npd0 = 0;
        npre = 0;
    endtask

    // short_row: row driven with only 10 pixels; rst_row: row where reset
    // is held low for the pixels at columns 5 and 6 (-1 disables either).
    task automatic run_frame(input int pat, input int short_row, input int rst_row);
        int n;
        pre_vsync = 1'b1;
        repeat (3) cyc();
        pre_vsync = 1'b0;
        repeat (2) cyc();
        for (int r = 0; r < V; r++) begin
            pre_hsync = 1'b1;
            repeat (2) cyc();
            pre_hsync = 1'b0;
            repeat (2) cyc();
            n = (r == short_row) ? 10 : H;
            for (int c = 0; c < n; c++) begin
                pre_de   = 1'b1;
                pre_data = pix(pat, r, c);
                cur_r    = 4'(r);
                cur_c    = 4'(c);
                npre++;
                if (r == rst_row && c == 5) rst_n = 1'b0;
                if (r == rst_row && c == 7) rst_n = 1'b1;
                cyc();
            end
            pre_de   = 1'b0;
            pre_data = 8'd0;
            repeat (3) cyc();
        end
        repeat (4) cyc();
    endtask

    typedef struct {
        int frame;
        int dut;     // 5 or 0: which OFFSET instance
        int r;
        int c;
        int exp;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vectors(input int frame);
        foreach (vecs[i]) begin
            if (vecs[i].frame == frame) begin
                chk($sformatf("vec f%0d dut%0d (%0d,%0d)", frame, vecs[i].dut, vecs[i].r, vecs[i].c),
                    (vecs[i].dut == 5) ? cap5[vecs[i].r][vecs[i].c] : cap0[vecs[i].r][vecs[i].c],
                    vecs[i].exp);
            end
        end
    endtask

    initial begin
        // Hand-computed spot values
        vecs.push_back('{1, 5, 0, 0, 0});
        vecs.push_back('{1, 5, 1, 5, 0});
        vecs.push_back('{1, 5, 2, 2, 255});
        vecs.push_back('{1, 5, 7, 15, 255});
        vecs.push_back('{1, 5, 5, 1, 0});
        vecs.push_back('{1, 0, 4, 4, 0});
        vecs.push_back('{2, 0, 5, 7, 255});
        vecs.push_back('{2, 0, 5, 6, 0});
        vecs.push_back('{2, 0, 5, 8, 0});
        vecs.push_back('{2, 0, 4, 7, 0});
        vecs.push_back('{2, 0, 6, 7, 0});
        vecs.push_back('{2, 0, 6, 8, 0});
        vecs.push_back('{2, 5, 5, 7, 255});
        vecs.push_back('{2, 5, 5, 6, 0});
        vecs.push_back('{2, 5, 2, 2, 255});
        vecs.push_back('{2, 5, 0, 5, 0});
        vecs.push_back('{4, 5, 2, 9, 255});
        vecs.push_back('{4, 5, 3, 15, 255});
        vecs.push_back('{4, 5, 3, 1, 0});
        vecs.push_back('{5, 5, 4, 10, 0});
        vecs.push_back('{5, 5, 5, 15, 0});
        vecs.push_back('{5, 5, 6, 2, 255});
        vecs.push_back('{5, 5, 6, 1, 0});
        vecs.push_back('{5, 5, 7, 15, 255});
        vecs.push_back('{5, 5, 3, 3, 255});

        for (int i = 0; i < 3; i++) tag_q[i] = '0;
        rst_n     = 1'b0;
        pre_hsync = 1'b0;
        pre_vsync = 1'b0;
        pre_de    = 1'b0;
        pre_data  = 8'd0;
        cur_r     = 4'd0;
        cur_c     = 4'd0;
        clear_caps();
        repeat (4) cyc();
        chk("reset_post_de", int'(pd5), 0);
        chk("reset_post_data", int'(pdat5), 0);
        chk("reset_post_hsync", int'(ph5), 0);
        chk("reset_post_vsync", int'(pv5), 0);
        rst_n = 1'b1;
        cyc();
        mon_en = 1'b1;

        // Frame 1: flat 100
        clear_caps();
        run_frame(0, -1, -1);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                chk($sformatf("f1 off5 (%0d,%0d)", r, c), cap5[r][c], exp_flat(r, c));
                chk($sformatf("f1 off0 (%0d,%0d)", r, c), cap0[r][c], 0);
            end
        end
        chk("f1 post_de count", npd5, 128);
        chk("f1 pre_de count", npre, 128);
        apply_vectors(1);

        // Frame 2: zero image with a single 200 at (4,6)
        clear_caps();
        run_frame(1, -1, -1);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                chk($sformatf("f2 off0 (%0d,%0d)", r, c), cap0[r][c], (r == 5 && c == 7) ? 255 : 0);
            end
        end
        chk("f2 post_de count", npd0, 128);
        apply_vectors(2);

        // Frame 3: flat again, stale RAM from frame 2 must not leak through
        clear_caps();
        run_frame(0, -1, -1);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                chk($sformatf("f3 off5 (%0d,%0d)", r, c), cap5[r][c], exp_flat(r, c));
            end
        end
        chk("f3 post_de count", npd5, 128);

        // Frame 4: row 2 is a 10-pixel short line
        clear_caps();
        run_frame(0, 2, -1);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (r != 2 || c < 10)
                    chk($sformatf("f4 off5 (%0d,%0d)", r, c), cap5[r][c], exp_flat(r, c));
            end
        end
        chk("f4 pre_de count", npre, 122);
        chk("f4 post_de count5", npd5, npre);
        chk("f4 post_de count0", npd0, npre);
        apply_vectors(4);

        // Frame 5: reset pulse mid-row 4; rows restart at 0 afterwards
        clear_caps();
        run_frame(0, -1, 4);
        for (int r = 0; r < V; r++) begin
            for (int c = 0; c < H; c++) begin
                if (r < 4)
                    chk($sformatf("f5 off5 (%0d,%0d)", r, c), cap5[r][c], exp_flat(r, c));
                else if ((r == 4 && c >= 7) || r == 5)
                    chk($sformatf("f5 off5 (%0d,%0d)", r, c), cap5[r][c], 0);
                else if (r >= 6)
                    chk($sformatf("f5 off5 (%0d,%0d)", r, c), cap5[r][c], (c >= 2) ? 255 : 0);
            end
        end
        apply_vectors(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
